// File: rtl/capture_rle_fifo_if.sv
// Handshake bundle between a producer/consumer and the capture FIFO.
// The FIFO attaches as slave; the surrounding logic (or bench) drives the master side.
interface capture_rle_fifo_if #(
    parameter int WIDTH   = 32,
    parameter int DEPTH_W = 5
);
    logic               flush_i;
    logic               wr_push_i;
    logic [WIDTH-1:0]   wr_data_i;
    logic               wr_full_o;
    logic               wr_afull_o;
    logic               rd_pop_i;
    logic [WIDTH-1:0]   rd_data_o;
    logic               rd_empty_o;
    logic [DEPTH_W:0]   level_o;
    logic               overflow_o;

    modport master (
        output flush_i, wr_push_i, wr_data_i, rd_pop_i,
        input  wr_full_o, wr_afull_o, rd_data_o, rd_empty_o, level_o, overflow_o
    );

    modport slave (
        input  flush_i, wr_push_i, wr_data_i, rd_pop_i,
        output wr_full_o, wr_afull_o, rd_data_o, rd_empty_o, level_o, overflow_o
    );
endinterface

// File: rtl/capture_rle_fifo_ram.sv
// Single-clock simple dual-port RAM, WIDTH x 2^DEPTH_W, registered read.
// Contents and read register are deliberately left unreset so the array maps to block RAM.
module capture_rle_fifo_ram #(
    parameter int WIDTH   = 32,
    parameter int DEPTH_W = 5
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [DEPTH_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]   wr_data,
    input  logic               rd_en,
    input  logic [DEPTH_W-1:0] rd_addr,
    output logic [WIDTH-1:0]   rd_data
);
    logic [WIDTH-1:0] mem [1<<DEPTH_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end
endmodule

// File: rtl/capture_rle_fifo.sv
// First-word-fall-through FIFO: block RAM with registered read, a RAM output stage and a skid
// register, so the head word is held stable while the RAM prefetches behind it.
module capture_rle_fifo #(
    parameter int WIDTH     = 32,
    parameter int DEPTH_W   = 5,
    parameter int AFULL_LVL = (1 << DEPTH_W) - 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    capture_rle_fifo_if.slave bus
);
    localparam int               DEPTH   = 1 << DEPTH_W;
    localparam logic [DEPTH_W:0] DEPTH_L = (DEPTH_W + 1)'(DEPTH);
    localparam logic [DEPTH_W:0] AFULL_L = (DEPTH_W + 1)'(AFULL_LVL);

    logic [DEPTH_W-1:0] wr_ptr_reg;
    logic [DEPTH_W-1:0] rd_ptr_reg;
    logic [DEPTH_W:0]   ram_cnt_reg;   // words in RAM not yet fetched into the output stages
    logic [DEPTH_W:0]   level_reg;
    logic               q_valid_reg;   // RAM read register holds a live word
    logic               skid_valid_reg;
    logic [WIDTH-1:0]   skid_data_reg;
    logic               overflow_reg;
    logic [WIDTH-1:0]   ram_q;

    logic full;
    logic head_valid;
    logic wr_acc;
    logic pop_acc;
    logic rd_en;

    assign full       = (level_reg == DEPTH_L);
    assign head_valid = skid_valid_reg | q_valid_reg;
    assign wr_acc     = bus.wr_push_i & ~full & ~bus.flush_i;
    assign pop_acc    = bus.rd_pop_i & head_valid & ~bus.flush_i;
    // Prefetch depends only on registered state, never on rd_pop_i.
    assign rd_en      = (ram_cnt_reg != '0) & ~(skid_valid_reg & q_valid_reg) & ~bus.flush_i;

    capture_rle_fifo_ram #(
        .WIDTH   (WIDTH),
        .DEPTH_W (DEPTH_W)
    ) u_ram (
        .clk     (clk_i),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr_reg),
        .wr_data (bus.wr_data_i),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr_reg),
        .rd_data (ram_q)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            ram_cnt_reg    <= '0;
            level_reg      <= '0;
            q_valid_reg    <= 1'b0;
            skid_valid_reg <= 1'b0;
            skid_data_reg  <= '0;
            overflow_reg   <= 1'b0;
        end else if (bus.flush_i) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            ram_cnt_reg    <= '0;
            level_reg      <= '0;
            q_valid_reg    <= 1'b0;
            skid_valid_reg <= 1'b0;
            overflow_reg   <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            ram_cnt_reg <= ram_cnt_reg + (DEPTH_W + 1)'(wr_acc) - (DEPTH_W + 1)'(rd_en);
            level_reg   <= level_reg + (DEPTH_W + 1)'(wr_acc) - (DEPTH_W + 1)'(pop_acc);
            if (bus.wr_push_i && full) begin
                overflow_reg <= 1'b1;
            end
            // The RAM word is consumed only when it is the head, i.e. the skid is empty.
            q_valid_reg <= rd_en | (q_valid_reg & ~(pop_acc & ~skid_valid_reg));
            if (skid_valid_reg) begin
                if (pop_acc) begin
                    skid_valid_reg <= 1'b0;
                end
            end else if (q_valid_reg && !pop_acc && rd_en) begin
                // Park the unpopped head before the prefetch overwrites the read register.
                skid_valid_reg <= 1'b1;
                skid_data_reg  <= ram_q;
            end
        end
    end

    assign bus.wr_full_o  = full;
    assign bus.wr_afull_o = (level_reg >= AFULL_L);
    assign bus.rd_empty_o = ~head_valid;
    assign bus.rd_data_o  = skid_valid_reg ? skid_data_reg : (q_valid_reg ? ram_q : '0);
    assign bus.level_o    = level_reg;
    assign bus.overflow_o = overflow_reg;
endmodule

// File: doc/capture_rle_fifo.md
CAPTURE_RLE_FIFO -- requirements
Module: capture_rle_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width in bits.
REQ-002 SHALL have parameter DEPTH_W, default 5, log2 of storage depth; DEPTH = 2^DEPTH_W.
REQ-003 SHALL have parameter AFULL_LVL, default DEPTH-4, almost-full threshold in entries.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock for all logic.
REQ-005 SHALL have port rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port flush_i, input, 1 bit: synchronous discard of all contents.
REQ-007 SHALL have port wr_push_i, input, 1 bit: write request.
REQ-008 SHALL have port wr_data_i, input, WIDTH bits: write data.
REQ-009 SHALL have port wr_full_o, output, 1 bit: no write accepted this cycle.
REQ-010 SHALL have port wr_afull_o, output, 1 bit: level_o >= AFULL_LVL.
REQ-011 SHALL have port rd_pop_i, input, 1 bit: consume the head word.
REQ-012 SHALL have port rd_data_o, output, WIDTH bits: head word, first-word-fall-through.
REQ-013 SHALL have port rd_empty_o, output, 1 bit: rd_data_o is not valid.
REQ-014 SHALL have port level_o, output, DEPTH_W+1 bits: count of words held.
REQ-015 SHALL have port overflow_o, output, 1 bit: sticky flag for a push rejected while full.

Function
REQ-016 SHALL accept a write when wr_push_i=1, wr_full_o=0 and flush_i=0.
REQ-017 SHALL consume the head word when rd_pop_i=1, rd_empty_o=0 and flush_i=0; a pop while empty SHALL be ignored.
REQ-018 SHALL count in level_o every accepted, unpopped word, including the output/skid stage; level_o SHALL range 0..DEPTH.
REQ-019 SHALL assert wr_full_o combinationally from registered state, exactly when level_o == DEPTH; a push and pop in the same full cycle SHALL reject the push and accept the pop.
REQ-020 SHALL update level_o by +1 for an accepted write only, -1 for an accepted pop only, and 0 for both or neither.
REQ-021 SHALL have fall-through latency such that a write accepted into an empty FIFO at cycle N drives rd_empty_o=0 with that data at cycle N+2 (registered RAM read plus output stage).
REQ-022 SHALL hold rd_data_o stable while rd_empty_o=0 and rd_pop_i=0; a skid register SHALL capture the RAM output so no word is lost or duplicated.
REQ-023 SHALL sustain one write and one pop per cycle indefinitely once non-empty, with no bubbles.
REQ-024 SHALL wrap read and write pointers modulo DEPTH; ordering SHALL be preserved across wrap.
REQ-025 SHALL set overflow_o on any cycle with wr_push_i=1, wr_full_o=1 and flush_i=0; it SHALL clear only on flush or reset.
REQ-026 SHALL, on flush_i=1, take effect at the next edge: pointers=0, level_o=0, rd_empty_o=1, skid invalid, overflow_o=0.
REQ-027 SHALL ignore a push or pop presented in the same cycle as flush_i=1.
REQ-028 SHALL drive rd_data_o to 0 whenever rd_empty_o=1.

Reset
REQ-029 SHALL, while rst_i=1, force: wr_full_o=0, wr_afull_o=(AFULL_LVL==0), rd_empty_o=1, rd_data_o=0, level_o=0, overflow_o=0, pointers=0.
REQ-030 SHALL discard all contents on reset mid-operation; the first accepted write after release SHALL be the first word read.
REQ-031 SHALL leave RAM contents unreset; they SHALL never be observable on rd_data_o before being written.

Structure
REQ-032 SHALL need no shared package; width, depth and threshold SHALL be module parameters only.
REQ-033 SHALL contain one sub-module, capture_rle_fifo_ram: single-clock simple dual-port RAM, WIDTH x DEPTH, registered read.
REQ-034 SHALL be synthesisable with no latches and no combinational path from rd_pop_i to wr_full_o.

Verification (WIDTH=32, DEPTH_W=2, AFULL_LVL=3)
REQ-035 SHALL cover: push 0xA1 into empty at cycle N -> rd_empty_o=0, rd_data_o=0xA1 at N+2, level_o=1.
REQ-036 SHALL cover: push 0x1..0x5 back-to-back, no pop -> 4 accepted, wr_full_o=1 after the 4th, wr_afull_o=1 at level 3, overflow_o=1, pops return 0x1..0x4.
REQ-037 SHALL cover: FIFO full, push 0x9 with a pop in the same cycle -> pop accepted, 0x9 rejected, level_o=3, overflow_o=1.
REQ-038 SHALL cover: 20 words streamed with push and pop every cycle, rd_pop_i toggled randomly -> output sequence identical to input across pointer wrap, no duplicates.
REQ-039 SHALL cover: level 3, flush_i=1 with push 0x7 -> next cycle level_o=0, rd_empty_o=1, overflow_o=0, and 0x7 never read.
REQ-040 SHALL cover: rst_i asserted asynchronously mid-stream at level 2 -> outputs immediately at the REQ-029 values; after release, push 0xB2 -> first read 0xB2.
